// File: rtl/fifo1c_stream.sv
// Single-clock FIFO: registered-read memory drained through a small prefetch buffer onto a valid/ready stream.
// Optional sticky overflow detection is compiled in with `define FIFO1C_OVF_CHK_EN.
module fifo1c_stream #(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = (1 << ADDR_WIDTH),
  parameter int DATA_WIDTH = 32,
  parameter int PIPE       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready,
  output logic                  err_ovf
);

  localparam int OB    = 2 + PIPE;
  localparam int OB_AW = $clog2(OB);
  localparam int MCW   = ADDR_WIDTH + 1;
  localparam int CW    = ADDR_WIDTH + 2;
  localparam logic [CW-1:0] CAP = CW'(DEPTH + OB);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [MCW-1:0]        mem_cnt_q, mem_cnt_d;
  logic [1:0]            inflight_q, inflight_d, ob_cnt_q, ob_cnt_d;
  logic [OB_AW-1:0]      ob_head_q, ob_head_d, ob_tail_q, ob_tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d, rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic [DATA_WIDTH-1:0] mem  [DEPTH];
  logic [DATA_WIDTH-1:0] ob_q [OB];
  logic [DATA_WIDTH-1:0] rd_word_p1, ret_word;
  logic                  vld_p1, ret_vld;

  logic       push, pop, issue;
  logic [2:0] occ;

  function automatic logic [OB_AW-1:0] ob_inc(input logic [OB_AW-1:0] p);
    return (p == OB_AW'(OB - 1)) ? '0 : p + OB_AW'(1);
  endfunction

  // Credit: words in flight plus buffered, after this cycle's pop, must leave room in the buffer.
  always_comb begin
    push = wr_en && !full_q;
    pop  = rd_valid_q && rd_ready;
    occ  = 3'(inflight_q) + 3'(ob_cnt_q) - 3'(pop);
    issue = (mem_cnt_q != '0) && (occ < 3'(OB));

    wr_ptr_d   = push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d   = issue ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    mem_cnt_d  = mem_cnt_q + MCW'(push) - MCW'(issue);
    inflight_d = inflight_q + 2'(issue) - 2'(ret_vld);
    ob_cnt_d   = ob_cnt_q + 2'(ret_vld) - 2'(pop);
    ob_head_d  = pop ? ob_inc(ob_head_q) : ob_head_q;
    ob_tail_d  = ret_vld ? ob_inc(ob_tail_q) : ob_tail_q;
    count_d    = CW'(mem_cnt_d) + CW'(inflight_d) + CW'(ob_cnt_d);
    full_d     = (count_d == CAP);

    // Next head may be the word landing in the buffer this very cycle.
    rd_data_d = '0;
    if (ob_cnt_d != 2'd0) begin
      if (ret_vld && (ob_tail_q == ob_head_d)) rd_data_d = ret_word;
      else                                     rd_data_d = ob_q[ob_head_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= '0;
      ob_cnt_q   <= '0;
      ob_head_q  <= '0;
      ob_tail_q  <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      vld_p1     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= inflight_d;
      ob_cnt_q   <= ob_cnt_d;
      ob_head_q  <= ob_head_d;
      ob_tail_q  <= ob_tail_d;
      count_q    <= count_d;
      full_q     <= full_d;
      rd_valid_q <= (ob_cnt_d != 2'd0);
      rd_data_q  <= rd_data_d;
      vld_p1     <= issue;
    end
  end

  // Stage p1: registered memory read; storage is never reset.
  always_ff @(posedge clk) begin
    if (push)    mem[wr_ptr_q]   <= wr_data;
    if (issue)   rd_word_p1      <= mem[rd_ptr_q];
    if (ret_vld) ob_q[ob_tail_q] <= ret_word;
  end

  // Stage p2: optional extra read register.
  generate
    if (PIPE != 0) begin : g_pipe
      logic [DATA_WIDTH-1:0] rd_word_p2;
      logic                  vld_p2;
      always_ff @(posedge clk) begin
        if (rst) vld_p2 <= 1'b0;
        else     vld_p2 <= vld_p1;
      end
      always_ff @(posedge clk) rd_word_p2 <= rd_word_p1;
      assign ret_vld  = vld_p2;
      assign ret_word = rd_word_p2;
    end else begin : g_nopipe
      assign ret_vld  = vld_p1;
      assign ret_word = rd_word_p1;
    end
  endgenerate

`ifdef FIFO1C_OVF_CHK_EN
  logic err_ovf_q;
  always_ff @(posedge clk) begin
    if (rst)                    err_ovf_q <= 1'b0;
    else if (wr_en && full_q)   err_ovf_q <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst) assert (!(wr_en && full_q)) else $error("fifo1c_stream: push dropped while full");
  end
  assign err_ovf = err_ovf_q;
`else
  assign err_ovf = 1'b0;
`endif

  assign full     = full_q;
  assign count    = count_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_fifo1c_stream.sv
// Directed bench for fifo1c_stream: latency (PIPE=0/1), fill/drain, streaming, random scoreboard, mid-stream reset.
module tb_fifo1c_stream;
  localparam int AW = 4;
  localparam int DW = 32;
`ifdef FIFO1C_OVF_CHK_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0, wr_en_b = 1'b0, rd_ready = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic          a_full, a_valid, a_err, b_full, b_valid, b_err;
  logic [AW+1:0] a_count, b_count;
  logic [DW-1:0] a_data, b_data;

  int checks = 0;
  int failures = 0;

  fifo1c_stream #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPE(0)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(a_full), .count(a_count),
    .rd_valid(a_valid), .rd_data(a_data), .rd_ready(rd_ready), .err_ovf(a_err));

  fifo1c_stream #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPE(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_data(wr_data), .full(b_full), .count(b_count),
    .rd_valid(b_valid), .rd_data(b_data), .rd_ready(rd_ready), .err_ovf(b_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] q[$];
    logic [DW-1:0] prev_data;
    logic          prev_stall, push, pop, started;
    int            cnt_m, exp_i;

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_count", a_count, 0);
    chk("rst_full", a_full, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_data", a_data, 0);
    chk("rst_err", a_err, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_b_count", b_count, 0);
    chk("rst_b_err", b_err, 0);
    rst = 1'b0;

    // Single-word latency, both pipeline depths
    rd_ready = 1'b1; wr_en = 1'b1; wr_en_b = 1'b1; wr_data = 32'hA5;
    step();
    wr_en = 1'b0; wr_en_b = 1'b0;
    chk("lat_cnt1", a_count, 1);
    chk("lat_a_v1", a_valid, 0);
    chk("lat_b_v1", b_valid, 0);
    step();
    chk("lat_a_v2", a_valid, 0);
    chk("lat_b_v2", b_valid, 0);
    step();
    chk("lat_a_v3", a_valid, 1);
    chk("lat_a_d3", a_data, 32'hA5);
    chk("lat_a_cnt3", a_count, 1);
    chk("lat_b_v3", b_valid, 0);
    step();
    chk("lat_a_v4", a_valid, 0);
    chk("lat_a_cnt4", a_count, 0);
    chk("lat_b_v4", b_valid, 1);
    chk("lat_b_d4", b_data, 32'hA5);
    step();
    chk("lat_b_v5", b_valid, 0);
    chk("lat_b_cnt5", b_count, 0);

    // Fill to capacity with consumer stalled, then drain
    rd_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_data = DW'(i);
      step();
      if (i == 16) begin
        chk("fill_cnt17", a_count, 17);
        chk("fill_nfull", a_full, 0);
      end
      if (i == 17) begin
        chk("fill_cnt18", a_count, 18);
        chk("fill_full", a_full, 1);
      end
    end
    wr_en = 1'b0;
    chk("fill_cnt_end", a_count, 18);
    chk("fill_full_end", a_full, 1);
    chk("fill_err", a_err, OVF_ON);
    rd_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      chk("drain_valid", a_valid, 1);
      chk("drain_data", a_data, DW'(i));
      step();
    end
    chk("drain_empty", a_valid, 0);
    chk("drain_cnt", a_count, 0);
    chk("drain_nfull", a_full, 0);
    chk("drain_err_sticky", a_err, OVF_ON);

    // Streaming at one word per cycle
    exp_i = 0; started = 1'b0;
    for (int c = 0; c < 140; c++) begin
      if (a_valid) begin
        started = 1'b1;
        chk("stream_data", a_data, 32'h1000 + DW'(exp_i));
        exp_i++;
      end else if (started && exp_i < 100) begin
        chk("stream_bubble", a_valid, 1);
      end
      chk("stream_cnt_max", a_count <= 3, 1);
      wr_en = (c < 100); wr_data = 32'h1000 + DW'(c);
      step();
    end
    wr_en = 1'b0;
    chk("stream_total", exp_i, 100);

    // Random traffic against a scoreboard
    cnt_m = 0; prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 3000; c++) begin
      if (prev_stall) begin
        chk("rand_hold_v", a_valid, 1);
        chk("rand_hold_d", a_data, prev_data);
      end
      wr_en = 1'($urandom_range(0, 1));
      rd_ready = 1'($urandom_range(0, 1));
      wr_data = $urandom;
      push = wr_en && (cnt_m != 18);
      pop = a_valid && rd_ready;
      if (pop) begin
        chk("rand_q_nonempty", q.size() != 0, 1);
        if (q.size() != 0) chk("rand_data", a_data, q.pop_front());
      end
      if (push) q.push_back(wr_data);
      prev_stall = a_valid && !rd_ready;
      prev_data = a_data;
      cnt_m = cnt_m + int'(push) - int'(pop);
      step();
      chk("rand_count", a_count, cnt_m);
      chk("rand_full", a_full, cnt_m == 18);
    end
    wr_en = 1'b0; rd_ready = 1'b1;
    for (int k = 0; k < 40 && q.size() != 0; k++) begin
      if (a_valid) chk("rand_drain_data", a_data, q.pop_front());
      step();
    end
    chk("rand_drain_q", q.size(), 0);
    chk("rand_drain_cnt", a_count, 0);

    // Reset with words held and a read in flight
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 32'h50 + DW'(i);
      step();
    end
    wr_en = 1'b0;
    chk("mid_cnt5", a_count, 5);
    rd_ready = 1'b1;
    step();
    chk("mid_cnt4", a_count, 4);
    rd_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_cnt", a_count, 0);
    chk("mid_rst_valid", a_valid, 0);
    chk("mid_rst_full", a_full, 0);
    chk("mid_rst_data", a_data, 0);
    chk("mid_rst_err", a_err, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_stale_valid", a_valid, 0);
      chk("mid_stale_cnt", a_count, 0);
    end
    wr_en = 1'b1; wr_data = 32'h77;
    step();
    wr_en = 1'b0; rd_ready = 1'b1;
    for (int k = 0; k < 8 && !a_valid; k++) step();
    chk("mid_new_valid", a_valid, 1);
    chk("mid_new_data", a_data, 32'h77);
    step();
    chk("mid_final_valid", a_valid, 0);
    chk("mid_final_cnt", a_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
